// File: rtl/video_timing_pkg.sv
// Shared encodings and 640x480@60 defaults for the video timing / test-pattern block.
package video_timing_pkg;

    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_GRID     = 2'd1,
        MODE_GRADIENT = 2'd2,
        MODE_SOLID    = 2'd3
    } mode_e;

    localparam int unsigned DEF_H_ACTIVE   = 640;
    localparam int unsigned DEF_H_FP       = 16;
    localparam int unsigned DEF_H_SYNC     = 96;
    localparam int unsigned DEF_H_BP       = 48;
    localparam int unsigned DEF_V_ACTIVE   = 480;
    localparam int unsigned DEF_V_FP       = 10;
    localparam int unsigned DEF_V_SYNC     = 2;
    localparam int unsigned DEF_V_BP       = 33;
    localparam bit          DEF_HSYNC_POL  = 1'b0;
    localparam bit          DEF_VSYNC_POL  = 1'b0;
    localparam int unsigned DEF_COLOR_BITS = 3;
    localparam int unsigned DEF_XY_BITS    = 10;
    localparam int unsigned NUM_BARS       = 8;

endpackage

// File: rtl/video_pattern_gen.sv
// Combinational test-pattern source: maps counter position, mode and frame count to RGB.
module video_pattern_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned COLOR_BITS = DEF_COLOR_BITS,
    parameter int unsigned XY_BITS    = DEF_XY_BITS
) (
    input  logic [XY_BITS-1:0]    h_cnt,
    input  logic [XY_BITS-1:0]    v_cnt,
    input  logic                  active,
    input  logic                  force_white,
    input  mode_e                 mode_q,
    input  logic [2:0]            bar_idx,
    input  logic [7:0]            frame_count,
    output logic [COLOR_BITS-1:0] red,
    output logic [COLOR_BITS-1:0] green,
    output logic [COLOR_BITS-1:0] blue
);

    logic [2:0] bar_color;
    logic       unused_bits;

    // colour = 7 - b, each channel all-ones when its bit is set
    assign bar_color   = ~bar_idx;
    // parity sink for counter bits no pattern looks at
    assign unused_bits = ^{h_cnt, v_cnt, frame_count};

    always_comb begin
        red   = '0;
        green = '0;
        blue  = '0;
        if (active) begin
            unique case (mode_q)
                MODE_BARS: begin
                    red   = {COLOR_BITS{bar_color[2]}};
                    green = {COLOR_BITS{bar_color[1]}};
                    blue  = {COLOR_BITS{bar_color[0]}};
                end
                MODE_GRID: begin
                    if (h_cnt[3:0] == 4'd0 || v_cnt[3:0] == 4'd0) begin
                        red   = '1;
                        green = '1;
                        blue  = '1;
                    end
                end
                MODE_GRADIENT: begin
                    red   = h_cnt[XY_BITS-1 -: COLOR_BITS];
                    green = v_cnt[XY_BITS-1 -: COLOR_BITS];
                    blue  = frame_count[7 -: COLOR_BITS];
                end
                MODE_SOLID: begin
                    red   = '1;
                    green = '1;
                    blue  = '1;
                end
                default: ;
            endcase
            if (force_white) begin
                red   = '1;
                green = '1;
                blue  = '1;
            end
        end
    end

endmodule

// File: rtl/video_timing_pattern.sv
// Parametrised video timing generator with test-pattern source, all outputs registered.
// Optional white active-area border when VIDEO_BORDER_EN is defined.
module video_timing_pattern
    import video_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter bit          HSYNC_POL  = DEF_HSYNC_POL,
    parameter bit          VSYNC_POL  = DEF_VSYNC_POL,
    parameter int unsigned COLOR_BITS = DEF_COLOR_BITS,
    parameter int unsigned XY_BITS    = DEF_XY_BITS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [1:0]            mode,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  blank,
    output logic [XY_BITS-1:0]    x,
    output logic [XY_BITS-1:0]    y,
    output logic [COLOR_BITS-1:0] red,
    output logic [COLOR_BITS-1:0] green,
    output logic [COLOR_BITS-1:0] blue,
    output logic                  line_start,
    output logic                  frame_start,
    output logic [7:0]            frame_count
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned BAR_W   = H_ACTIVE / NUM_BARS;

    logic [XY_BITS-1:0]    h_cnt, v_cnt, bar_pix;
    logic [2:0]            bar_idx;
    mode_e                 mode_q, mode_eff;
    logic                  h_last, v_last, at_origin, active;
    logic                  in_hsync, in_vsync, force_white;
    logic [7:0]            frame_next;
    logic [COLOR_BITS-1:0] pat_r, pat_g, pat_b;

    assign h_last    = (h_cnt == XY_BITS'(H_TOTAL - 1));
    assign v_last    = (v_cnt == XY_BITS'(V_TOTAL - 1));
    assign at_origin = (h_cnt == '0) && (v_cnt == '0);
    assign active    = (h_cnt < XY_BITS'(H_ACTIVE)) && (v_cnt < XY_BITS'(V_ACTIVE));
    assign in_hsync  = (h_cnt >= XY_BITS'(H_ACTIVE + H_FP)) &&
                       (h_cnt <  XY_BITS'(H_ACTIVE + H_FP + H_SYNC));
    assign in_vsync  = (v_cnt >= XY_BITS'(V_ACTIVE + V_FP)) &&
                       (v_cnt <  XY_BITS'(V_ACTIVE + V_FP + V_SYNC));

    // The origin pixel already renders with the newly latched mode and count,
    // so every pixel of a frame shares one mode and matches frame_count.
    assign mode_eff   = at_origin ? mode_e'(mode) : mode_q;
    assign frame_next = at_origin ? frame_count + 8'd1 : frame_count;

`ifdef VIDEO_BORDER_EN
    assign force_white = active &&
                         (h_cnt == '0 || h_cnt == XY_BITS'(H_ACTIVE - 1) ||
                          v_cnt == '0 || v_cnt == XY_BITS'(V_ACTIVE - 1));
`else
    assign force_white = 1'b0;
`endif

    video_pattern_gen #(
        .COLOR_BITS(COLOR_BITS),
        .XY_BITS   (XY_BITS)
    ) u_pattern (
        .h_cnt      (h_cnt),
        .v_cnt      (v_cnt),
        .active     (active),
        .force_white(force_white),
        .mode_q     (mode_eff),
        .bar_idx    (bar_idx),
        .frame_count(frame_next),
        .red        (pat_r),
        .green      (pat_g),
        .blue       (pat_b)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            bar_idx     <= '0;
            bar_pix     <= '0;
            mode_q      <= MODE_BARS;
            frame_count <= '0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            blank       <= 1'b1;
            x           <= '0;
            y           <= '0;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (enable) begin
            h_cnt <= h_last ? '0 : h_cnt + 1'b1;
            if (h_last) begin
                v_cnt <= v_last ? '0 : v_cnt + 1'b1;
            end
            // bar tracker follows h_cnt; remainder pixels stay in the last bar
            if (h_last) begin
                bar_idx <= '0;
                bar_pix <= '0;
            end else if (bar_idx != 3'd7) begin
                if (bar_pix == XY_BITS'(BAR_W - 1)) begin
                    bar_idx <= bar_idx + 3'd1;
                    bar_pix <= '0;
                end else begin
                    bar_pix <= bar_pix + 1'b1;
                end
            end
            mode_q      <= mode_eff;
            frame_count <= frame_next;
            hsync       <= in_hsync ? HSYNC_POL : ~HSYNC_POL;
            vsync       <= in_vsync ? VSYNC_POL : ~VSYNC_POL;
            blank       <= ~active;
            x           <= h_cnt;
            y           <= v_cnt;
            red         <= pat_r;
            green       <= pat_g;
            blue        <= pat_b;
            line_start  <= (h_cnt == '0);
            frame_start <= at_origin;
        end else begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule
